// File: rtl/maj_net_pkg.sv
// Shared definitions for the majority-network sequencer:
// select codes, FSM states and a reference MAJ3 function.
package maj_net_pkg;

    localparam int SEL_X0        = 0;
    localparam int SEL_X1        = 1;
    localparam int SEL_X2        = 2;
    localparam int SEL_X3        = 3;
    localparam int SEL_X4        = 4;
    localparam int SEL_X5        = 5;
    localparam int SEL_X6        = 6;
    localparam int SEL_ZERO      = 7;
    localparam int SEL_GATE_BASE = 8;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/maj_net_sequencer_if.sv
// Host-side config/start bus and truth-table result of the
// majority-network sequencer.
interface maj_net_sequencer_if #(
    parameter int NGATES = 8
);
    localparam int SELW = $clog2(8 + NGATES);
    localparam int AW   = (NGATES > 1) ? $clog2(NGATES) : 1;
    localparam int NW   = $clog2(NGATES + 1);

    logic            cfg_we;
    logic [AW-1:0]   cfg_addr;
    logic [SELW-1:0] cfg_a;
    logic [SELW-1:0] cfg_b;
    logic [SELW-1:0] cfg_c;
    logic [NW-1:0]   cfg_n;
    logic [SELW-1:0] out_sel;
    logic            start;
    logic            busy;
    logic            done;
    logic [127:0]    tt;

    modport master (
        output cfg_we, cfg_addr, cfg_a, cfg_b, cfg_c,
        output cfg_n, out_sel, start,
        input  busy, done, tt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_a, cfg_b, cfg_c,
        input  cfg_n, out_sel, start,
        output busy, done, tt
    );

endinterface

// File: rtl/maj3_cell.sv
// Shared three-input majority cell, time-multiplexed
// across all configured gates.
module maj3_cell
    import maj_net_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = maj3(a, b, c);

endmodule

// File: rtl/maj_net_sequencer.sv
// Evaluates a configured MAJ3 netlist for all 128 input
// vectors, one gate per cycle, and returns a net's truth table.
module maj_net_sequencer
    import maj_net_pkg::*;
#(
    parameter int NGATES = 8
) (
    input logic                clk,
    input logic                rst,
    maj_net_sequencer_if.slave bus
);

    localparam int SELW = $clog2(8 + NGATES);
    localparam int AW   = (NGATES > 1) ? $clog2(NGATES) : 1;
    localparam int NW   = $clog2(NGATES + 1);

    logic [SELW-1:0]   sel_a [NGATES];
    logic [SELW-1:0]   sel_b [NGATES];
    logic [SELW-1:0]   sel_c [NGATES];
    state_t            state;
    state_t            state_nx;
    logic [NW-1:0]     n_q;
    logic [NW-1:0]     n_clamp;
    logic [SELW-1:0]   osel_q;
    logic [6:0]        v;
    logic [AW-1:0]     g;
    logic [NGATES-1:0] gv;
    logic [NGATES-1:0] gv_fwd;
    logic [127:0]      tt_q;
    logic              op_a;
    logic              op_b;
    logic              op_c;
    logic              res;
    logic              out_bit;
    logic              last_g;
    logic              accept;

    function automatic logic pick(
        input logic [SELW-1:0]   s,
        input logic [6:0]        vv,
        input logic [NGATES-1:0] gs
    );
        logic r;
        r = 1'b0;
        for (int k = 0; k < 7; k++)
            if (int'(s) == SEL_X0 + k) r = vv[k];
        for (int k = 0; k < NGATES; k++)
            if (int'(s) == SEL_GATE_BASE + k) r = gs[k];
        return r;
    endfunction

    assign last_g = (int'(g) == int'(n_q) - 1);
    assign accept = (state == IDLE) && bus.start;

    assign op_a = pick(sel_a[g], v, gv);
    assign op_b = pick(sel_b[g], v, gv);
    assign op_c = pick(sel_c[g], v, gv);

    maj3_cell u_maj3 (
        .a (op_a),
        .b (op_b),
        .c (op_c),
        .y (res)
    );

    // The output net may be the gate finishing this cycle.
    always_comb begin
        gv_fwd    = gv;
        gv_fwd[g] = res;
    end

    assign out_bit = pick(osel_q, v, gv_fwd);

    always_comb begin
        n_clamp = bus.cfg_n;
        if (bus.cfg_n == '0)
            n_clamp = NW'(1);
        else if (int'(bus.cfg_n) > NGATES)
            n_clamp = NW'(NGATES);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start) state_nx = EVAL;
            EVAL: if (last_g && v == 7'd127) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy = (state == EVAL);
    assign bus.done = (state == DONE);
    assign bus.tt   = tt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NGATES; k++) begin
                sel_a[k] <= SELW'(SEL_ZERO);
                sel_b[k] <= SELW'(SEL_ZERO);
                sel_c[k] <= SELW'(SEL_ZERO);
            end
            n_q    <= NW'(1);
            osel_q <= SELW'(SEL_ZERO);
            v      <= '0;
            g      <= '0;
            gv     <= '0;
            tt_q   <= '0;
        end else if (state == IDLE) begin
            if (bus.cfg_we) begin
                sel_a[bus.cfg_addr] <= bus.cfg_a;
                sel_b[bus.cfg_addr] <= bus.cfg_b;
                sel_c[bus.cfg_addr] <= bus.cfg_c;
            end
            if (accept) begin
                n_q    <= n_clamp;
                osel_q <= bus.out_sel;
                v      <= '0;
                g      <= '0;
                gv     <= '0;
            end
        end else if (state == EVAL) begin
            // Clearing gate values per vector makes forward refs read 0.
            if (last_g) begin
                tt_q[v] <= out_bit;
                g       <= '0;
                v       <= v + 7'd1;
                gv      <= '0;
            end else begin
                gv[g] <= res;
                g     <= g + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_maj_net_sequencer.sv
// Scoreboard bench for maj_net_sequencer: expected truth
// tables and latencies are queued at start, compared on done.
module tb_maj_net_sequencer;
    import maj_net_pkg::*;

    localparam int NGATES = 8;
    localparam int SELW   = 4;
    localparam int AW     = 3;
    localparam int NW     = 4;
    localparam logic [127:0] TT_TWO_LEVEL =
        128'hfeeaeee8fae8a880feeae8a0e888a880;

    typedef struct {
        logic [127:0] tt;
        int           lat;
        int           t0;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ca [NGATES];
    int   cb [NGATES];
    int   cc [NGATES];
    exp_t sb [$];
    exp_t cur;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maj_net_sequencer_if #(.NGATES(NGATES)) bus ();

    maj_net_sequencer #(.NGATES(NGATES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic rd(input int s, input logic [6:0] vv,
                                input logic [NGATES-1:0] gs);
        logic [NGATES-1:0] t;
        if (s <= SEL_X6) return vv[s[2:0]];
        if (s == SEL_ZERO) return 1'b0;
        if (s - SEL_GATE_BASE < NGATES) begin
            t = gs >> (s - SEL_GATE_BASE);
            return t[0];
        end
        return 1'b0;
    endfunction

    function automatic logic [127:0] model(input int n, input int os);
        logic [127:0]      r;
        logic [NGATES-1:0] gs;
        logic [6:0]        vv;
        logic              b;
        r = '0;
        for (int v = 0; v < 128; v++) begin
            gs = '0;
            vv = 7'(v);
            for (int k = 0; k < n; k++) begin
                b  = maj3(rd(ca[k], vv, gs), rd(cb[k], vv, gs),
                          rd(cc[k], vv, gs));
                gs = gs | (NGATES'(b) << k);
            end
            r = r | (128'(rd(os, vv, gs)) << v);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 128'(bus.done), 128'(0));
            end else begin
                cur = sb.pop_front();
                check({cur.tag, "_tt"}, bus.tt, cur.tt);
                check({cur.tag, "_lat"}, 128'(cyc - cur.t0),
                      128'(cur.lat));
            end
        end
    end

    task automatic cfg_gate(input int k, input int a, input int b,
                            input int c);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(k);
        bus.cfg_a    = SELW'(a);
        bus.cfg_b    = SELW'(b);
        bus.cfg_c    = SELW'(c);
        @(negedge clk);
        bus.cfg_we = 1'b0;
        ca[k] = a;
        cb[k] = b;
        cc[k] = c;
    endtask

    task automatic cfg_two_level();
        cfg_gate(0, 0, 1, 2);
        cfg_gate(1, 4, 5, 6);
        cfg_gate(2, 0, 1, 5);
        cfg_gate(3, 0, 2, 4);
        cfg_gate(4, 3, 8, 9);
        cfg_gate(5, 10, 11, 12);
    endtask

    task automatic sweep(input string tag, input int n_in, input int os,
                         input logic [127:0] exp, input int n_eff,
                         input bit disturb, input bit start_in_done);
        exp_t e;
        int   limit;
        limit = 128 * NGATES + 32;
        @(negedge clk);
        bus.cfg_n   = NW'(n_in);
        bus.out_sel = SELW'(os);
        bus.start   = 1'b1;
        e.tt  = exp;
        e.lat = 128 * n_eff + 1;
        e.t0  = cyc;
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, 128'(bus.busy), 128'(1));
        for (int k = 0; k < limit && bus.done !== 1'b1; k++) begin
            if (disturb && k == 100) begin
                bus.start    = 1'b1;
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = '0;
                bus.cfg_a    = SELW'(SEL_ZERO);
                bus.cfg_b    = SELW'(SEL_ZERO);
                bus.cfg_c    = SELW'(SEL_ZERO);
            end else if (disturb && k == 101) begin
                bus.start  = 1'b0;
                bus.cfg_we = 1'b0;
            end
            @(negedge clk);
        end
        if (bus.done !== 1'b1) begin
            check({tag, "_timeout"}, 128'(bus.done), 128'(1));
            sb.delete();
        end
        if (start_in_done) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            repeat (4) @(negedge clk);
            check({tag, "_no_restart"}, 128'(bus.busy), 128'(0));
        end
    endtask

    initial begin
        int os;
        rst          = 1'b1;
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = '0;
        bus.cfg_a    = '0;
        bus.cfg_b    = '0;
        bus.cfg_c    = '0;
        bus.cfg_n    = '0;
        bus.out_sel  = '0;
        bus.start    = 1'b0;
        for (int k = 0; k < NGATES; k++) begin
            ca[k] = SEL_ZERO;
            cb[k] = SEL_ZERO;
            cc[k] = SEL_ZERO;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 128'(bus.busy), 128'(0));
        check("rst_done", 128'(bus.done), 128'(0));
        check("rst_tt", bus.tt, 128'(0));

        cfg_two_level();
        sweep("two_level", 6, 13, TT_TWO_LEVEL, 6, 1'b0, 1'b0);
        sweep("disturbed", 6, 13, TT_TWO_LEVEL, 6, 1'b1, 1'b1);

        cfg_gate(0, 0, 1, 2);
        sweep("single", 1, 8, {16{8'he8}}, 1, 1'b0, 1'b0);
        sweep("n_zero", 0, 8, {16{8'he8}}, 1, 1'b0, 1'b0);
        cfg_gate(0, 8, 0, 1);
        sweep("self_ref", 1, 8, {16{8'h88}}, 1, 1'b0, 1'b0);
        sweep("sel_x0", 1, 0, {16{8'haa}}, 1, 1'b0, 1'b0);
        sweep("sel_zero", 1, 7, 128'(0), 1, 1'b0, 1'b0);

        for (int k = 0; k < NGATES; k++)
            cfg_gate(k, $urandom_range(0, 8 + k), $urandom_range(0, 8 + k),
                     $urandom_range(0, 15));
        os = $urandom_range(8, 15);
        sweep("rand_clamp", 15, os, model(NGATES, os), NGATES,
              1'b0, 1'b0);

        cfg_two_level();
        @(negedge clk);
        bus.cfg_n   = NW'(6);
        bus.out_sel = SELW'(13);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (299) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NGATES; k++) begin
            ca[k] = SEL_ZERO;
            cb[k] = SEL_ZERO;
            cc[k] = SEL_ZERO;
        end
        check("abort_busy", 128'(bus.busy), 128'(0));
        check("abort_done", 128'(bus.done), 128'(0));
        check("abort_tt", bus.tt, 128'(0));
        sweep("post_rst", 1, 13, 128'(0), 1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/maj_net_sequencer.md
# maj_net_sequencer

Programmable majority-network evaluator for the 7-input classification flow. Holds a netlist of up to NGATES three-input majority gates in configuration registers and time-multiplexes one shared MAJ3 cell across the gates. Sweeps all 128 input vectors and returns the 128-bit truth table of a chosen net. Sits between the host/config bus and the classification compare logic, replacing one hand-written combinational network per function.

## Interface

- NGATES, 8, maximum number of gates in a network (1..24)
- SELW, $clog2(8+NGATES), operand select width (derived, not overridden)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write one gate's operand selects; ignored while busy
- cfg_addr  in  $clog2(NGATES)  gate index to write
- cfg_a, cfg_b, cfg_c  in  SELW each  operand selects for gate cfg_addr
- cfg_n  in  $clog2(NGATES+1)  gate count; sampled on start
- out_sel  in  SELW  net whose truth table is captured; sampled on start
- start  in  1  begin a sweep; honoured only in IDLE
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; tt valid from this cycle
- tt  out  128  truth table, tt[v] = net value for input vector v

## Operation

- Select encoding: 0..6 = x0..x6 where xi = bit i of vector index v; 7 = constant 0; 8+k = output of gate k; codes ≥ 8+NGATES read 0.
- Each gate computes out_k = MAJ(a, b, c) = ab | ac | bc; no inversion.
- States: IDLE, EVAL, DONE.
- IDLE: accepts cfg_we writes. On start: latch cfg_n (0 treated as 1; values > NGATES clamped to NGATES) and out_sel, clear v and g, clear all gate value registers, go to EVAL.
- EVAL: each cycle evaluates gate g for vector v through the shared MAJ3 and stores the result in gate register g.
- Operand reads see gate registers as updated so far for the current vector. Gate registers clear to 0 when v advances, so forward and self references read 0.
- On g = n-1:
  - capture tt[v] = value of out_sel, with the gate n-1 result forwarded in the same cycle;
  - g wraps to 0 and v increments;
  - on v = 127, go to DONE.
- DONE: done = 1 for one cycle, busy = 0, then IDLE.
- tt holds until the next accepted start. tt bits are overwritten progressively during a sweep; tt is not guaranteed valid while busy.
- cfg_we and start while busy are ignored without error.

## Timing

- Reset values: busy = 0, done = 0, tt = 0. All gate operand selects = 7 (constant 0). cfg_n latch = 1. State = IDLE.
- start at cycle t: busy = 1 from t+1. First evaluation (v = 0, g = 0) at t+1. done at t+1+128·n, together with busy = 0.
- Back-to-back: start asserted in the DONE cycle is ignored. Start is accepted from the following IDLE cycle.
- rst in any state aborts the sweep. Next cycle: reset values, config included.
- No combinational path from start or cfg inputs to any output.

## Structure

- Package maj_net_pkg:
  - select-code constants SEL_X0..SEL_X6, SEL_ZERO = 7, SEL_GATE_BASE = 8;
  - state enum {IDLE, EVAL, DONE};
  - maj3 function for reference models.
- Sub-module maj3_cell: pure combinational 3-input majority, instantiated once.
- Operand muxes, gate registers, v/g counters and FSM stay in the top.

## Test plan

- Two-level majority network, n = 6, out_sel = 13:
  - g0 = (0,1,2), g1 = (4,5,6), g2 = (0,1,5), g3 = (0,2,4), g4 = (3,8,9), g5 = (10,11,12);
  - required: tt = 0xfeeaeee8fae8a880feeae8a0e888a880, done exactly 769 cycles after start.
- Single gate, n = 1, g0 = (0,1,2), out_sel = 8 → tt = 0xe8 repeated 16 times; done at t+129.
- Self reference, n = 1, g0 = (8,0,1), out_sel = 8 → tt = 0x88 repeated 16 times (x0·x1).
- out_sel = 0 → tt = 0xaa repeated 16 times. out_sel = 7 → tt = 0.
- Overlapping inputs during a sweep:
  - start and cfg_we (gate 0 ← (7,7,7)) pulsed mid-sweep → ignored, result identical to the undisturbed run;
  - start in the DONE cycle → no new sweep.
- rst asserted 300 cycles into the 6-gate sweep:
  - next cycle busy = 0, done = 0, tt = 0;
  - start with no reconfiguration → tt = 0, done at t+129 (n = 1).
